// File: rtl/ab_chk_pkg.sv
// Shared types and constants for the AND-block self-test checker.
package ab_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } ab_chk_state_t;

   localparam int unsigned          AB_VEC_NUM = 4;
   localparam int unsigned          AB_ERR_W   = 8;
   localparam logic [AB_ERR_W-1:0]  AB_ERR_MAX = 8'd255;
   localparam logic [1:0]           AB_VEC_LAST = 2'(AB_VEC_NUM - 1);

endpackage

// File: rtl/ab_err_sat_cnt.sv
// Saturating mismatch counter: synchronous clear, adds 0/1/2 per cycle, sticks at AB_ERR_MAX.
module ab_err_sat_cnt
   import ab_chk_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic [1:0]          inc,
   output logic [AB_ERR_W-1:0] cnt
);

   logic [AB_ERR_W-1:0] cnt_q;
   logic [AB_ERR_W-1:0] cnt_d;
   logic [AB_ERR_W:0]   sum;

   always_comb begin
      sum = {1'b0, cnt_q} + {{(AB_ERR_W - 1){1'b0}}, inc};
      // AB_ERR_MAX is all ones, so any carry out means the sum went past it
      if (clr) begin
         cnt_d = '0;
      end else if (sum[AB_ERR_W]) begin
         cnt_d = AB_ERR_MAX;
      end else begin
         cnt_d = sum[AB_ERR_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/ab_stim_checker.sv
// Closed-loop stimulus generator and checker for the two-input AND block.
// Define AB_CHK_C2_EN to also check the combinational output pi_c2.
module ab_stim_checker
   import ab_chk_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pi_start,
   output logic                po_a,
   output logic                po_b,
   input  logic                pi_c1,
   input  logic                pi_c2,
   output logic                po_busy,
   output logic                po_done,
   output logic                po_pass,
   output logic [AB_ERR_W-1:0] po_err_cnt
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   ab_chk_state_t state_q, state_d;
   logic [1:0]    vec_q, vec_d;
   logic [7:0]    hold_q, hold_d;
   logic          a_q, a_d;
   logic          b_q, b_d;
   logic          pass_q, pass_d;

   logic          exp_bit;
   logic          c1_miss;
   logic          c2_miss;
   logic          cnt_clr;
   logic [1:0]    cnt_inc;
   logic [AB_ERR_W-1:0] err_cnt;

   assign exp_bit = a_q & b_q;
   // At h=0 the registered output still carries the previous vector's result
   assign c1_miss = (hold_q != 8'd0) && (pi_c1 != exp_bit);

`ifdef AB_CHK_C2_EN
   assign c2_miss = (pi_c2 != exp_bit);
`else
   logic c2_unused;
   assign c2_unused = pi_c2;
   assign c2_miss   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      hold_d  = hold_q;
      a_d     = a_q;
      b_d     = b_q;
      pass_d  = pass_q;
      cnt_clr = 1'b0;
      cnt_inc = 2'd0;
      case (state_q)
         IDLE: begin
            if (pi_start) begin
               vec_d   = 2'd0;
               hold_d  = 8'd0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               pass_d  = 1'b0;
               cnt_clr = 1'b1;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            cnt_inc = {1'b0, c1_miss} + {1'b0, c2_miss};
            if (hold_q == HOLD_LAST) begin
               hold_d = 8'd0;
               if (vec_q == AB_VEC_LAST) begin
                  a_d     = 1'b0;
                  b_d     = 1'b0;
                  // Saturation never wraps, so a clean run means nothing was ever added
                  pass_d  = (err_cnt == '0) && (cnt_inc == 2'd0);
                  state_d = DONE;
               end else begin
                  vec_d      = vec_q + 2'd1;
                  {a_d, b_d} = vec_d;
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= 2'd0;
         hold_q  <= 8'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pass_q  <= pass_d;
      end
   end

   ab_err_sat_cnt u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (err_cnt)
   );

   assign po_a       = a_q;
   assign po_b       = b_q;
   assign po_busy    = (state_q == DRIVE);
   assign po_done    = (state_q == DONE);
   assign po_pass    = pass_q;
   assign po_err_cnt = err_cnt;

endmodule
